// File: rtl/gyro_pkg.sv
// Shared definitions for the gyro processing chain: calibration FSM states,
// default widths and the saturating subtract used by every gyro stage.
package gyro_pkg;

  localparam int unsigned GYRO_DATA_W       = 16;
  localparam int unsigned GYRO_LOG2_SAMPLES = 10;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    CAL
  } gyro_cal_state_t;

  // a - b evaluated one bit wider than the operands, clamped to a signed w-bit range.
  function automatic logic signed [32:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w);
    logic signed [32:0] diff;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    diff  = $signed({a[31], a}) - $signed({b[31], b});
    max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (w - 1));
    if (diff > max_v) return max_v;
    if (diff < min_v) return min_v;
    return diff;
  endfunction

endpackage

// File: rtl/gyro_axis_cal.sv
// One gyro axis: bias accumulator, committed bias register and the registered
// saturating bias subtraction.
module gyro_axis_cal
  import gyro_pkg::*;
#(
  parameter int unsigned DATA_W       = GYRO_DATA_W,
  parameter int unsigned LOG2_SAMPLES = GYRO_LOG2_SAMPLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acc_clr_i,
  input  logic                     acc_en_i,
  input  logic                     bias_load_i,
  input  logic                     sample_valid_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] corr_o
);

  // Sum of 2^LOG2_SAMPLES DATA_W-bit samples always fits in this width.
  localparam int unsigned ACC_W = DATA_W + LOG2_SAMPLES;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic signed [DATA_W-1:0] corr_q, corr_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    acc_d  = acc_q;
    bias_d = bias_q;
    corr_d = corr_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(sample_i);
    end
    // Arithmetic shift floors the mean, so negative averages round down.
    if (bias_load_i) begin
      bias_d = DATA_W'(acc_q >>> LOG2_SAMPLES);
    end
    if (sample_valid_i) begin
      corr_d = DATA_W'(sat_sub(32'(sample_i), 32'(bias_q), DATA_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values regardless of statement order.
    if (!rst_n) begin
      acc_q  <= '0;
      bias_q <= '0;
      corr_q <= '0;
    end else begin
      acc_q  <= acc_d;
      bias_q <= bias_d;
      corr_q <= corr_d;
    end
  end

  assign corr_o = corr_q;

endmodule

// File: rtl/gyro_bias_cal.sv
// Gyro zero-rate bias calibrator: averages stationary samples on request and
// subtracts the resulting per-axis bias, with saturation, from every sample.
module gyro_bias_cal
  import gyro_pkg::*;
#(
  parameter int unsigned LOG2_SAMPLES = GYRO_LOG2_SAMPLES,
  parameter int unsigned DATA_W       = GYRO_DATA_W
) (
  input  logic                     clk_100mhz,
  input  logic                     reset_n,
  input  logic                     cal_start,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] gx,
  input  logic signed [DATA_W-1:0] gy,
  input  logic signed [DATA_W-1:0] gz,
  output logic signed [DATA_W-1:0] gx_corr,
  output logic signed [DATA_W-1:0] gy_corr,
  output logic signed [DATA_W-1:0] gz_corr,
  output logic                     corr_valid,
  output logic                     busy,
  output logic                     cal_done
);

  localparam logic [LOG2_SAMPLES-1:0] COUNT_LAST = '1;

  gyro_cal_state_t         state_q, state_d;
  logic                    sync1_q, sync2_q, start_prev_q;
  logic                    start_edge;
  logic [LOG2_SAMPLES-1:0] count_q, count_d;
  logic                    corr_valid_q;
  logic                    cal_done_q, cal_done_d;
  logic                    acc_clr, acc_en, bias_load;

  // cal_start is an asynchronous switch: two-flop synchroniser, then rising-edge detect.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      sync1_q      <= cal_start;
      sync2_q      <= sync1_q;
      start_prev_q <= sync2_q;
    end
  end

  assign start_edge = sync2_q & ~start_prev_q;

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_edge) state_d = ACCUM;
      ACCUM: begin
        if (start_edge) begin
          state_d = ACCUM;
        end else if (sample_valid && (count_q == COUNT_LAST)) begin
          state_d = DIVIDE;
        end
      end
      DIVIDE:  state_d = CAL;
      CAL:     if (start_edge) state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // A start edge in the same cycle as a sample wins: the sample is not accumulated.
  always_comb begin
    busy      = (state_q == ACCUM) || (state_q == DIVIDE);
    acc_clr   = start_edge && (state_q != DIVIDE);
    acc_en    = (state_q == ACCUM) && sample_valid && !start_edge;
    bias_load = (state_q == DIVIDE);
  end

  always_comb begin
    count_d    = count_q;
    cal_done_d = cal_done_q | bias_load;
    if (acc_clr) begin
      count_d = '0;
    end else if (acc_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      corr_valid_q <= 1'b0;
      cal_done_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      corr_valid_q <= sample_valid;
      cal_done_q   <= cal_done_d;
    end
  end

  assign corr_valid = corr_valid_q;
  assign cal_done   = cal_done_q;

  gyro_axis_cal #(.DATA_W(DATA_W), .LOG2_SAMPLES(LOG2_SAMPLES)) u_axis_x (
    .clk(clk_100mhz), .rst_n(reset_n), .acc_clr_i(acc_clr), .acc_en_i(acc_en),
    .bias_load_i(bias_load), .sample_valid_i(sample_valid), .sample_i(gx), .corr_o(gx_corr)
  );

  gyro_axis_cal #(.DATA_W(DATA_W), .LOG2_SAMPLES(LOG2_SAMPLES)) u_axis_y (
    .clk(clk_100mhz), .rst_n(reset_n), .acc_clr_i(acc_clr), .acc_en_i(acc_en),
    .bias_load_i(bias_load), .sample_valid_i(sample_valid), .sample_i(gy), .corr_o(gy_corr)
  );

  gyro_axis_cal #(.DATA_W(DATA_W), .LOG2_SAMPLES(LOG2_SAMPLES)) u_axis_z (
    .clk(clk_100mhz), .rst_n(reset_n), .acc_clr_i(acc_clr), .acc_en_i(acc_en),
    .bias_load_i(bias_load), .sample_valid_i(sample_valid), .sample_i(gz), .corr_o(gz_corr)
  );

endmodule

// File: tb/tb_gyro_bias_cal.sv
// Directed and randomized checks of gyro_bias_cal (16-sample calibrations)
// against an arithmetic model of mean-and-subtract.
module tb_gyro_bias_cal;

  localparam int LOG2 = 4;
  localparam int N    = 1 << LOG2;
  localparam int DW   = 16;

  logic                 clk_100mhz = 1'b0;
  logic                 reset_n    = 1'b0;
  logic                 cal_start  = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] gx = '0, gy = '0, gz = '0;
  logic signed [DW-1:0] gx_corr, gy_corr, gz_corr;
  logic                 corr_valid, busy, cal_done;

  int checks   = 0;
  int failures = 0;
  int bias_m[3];
  int cal_v[3][N];
  int busy_cycles = 0;

  gyro_bias_cal #(.LOG2_SAMPLES(LOG2), .DATA_W(DW)) dut (
    .clk_100mhz(clk_100mhz), .reset_n(reset_n), .cal_start(cal_start),
    .sample_valid(sample_valid), .gx(gx), .gy(gy), .gz(gz),
    .gx_corr(gx_corr), .gy_corr(gy_corr), .gz_corr(gz_corr),
    .corr_valid(corr_valid), .busy(busy), .cal_done(cal_done)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #500us;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_corr(input int x, input int b);
    int d;
    d = x - b;
    if (d > 32767) return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  function automatic int rnd_full();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
    if (busy) busy_cycles++;
  endtask

  // One sample in, corrected result checked one cycle later against the committed model bias.
  task automatic send(input int x, input int y, input int z, input string tag);
    gx = DW'(x);
    gy = DW'(y);
    gz = DW'(z);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check({tag, "_valid"}, corr_valid, 1);
    check({tag, "_gx"}, gx_corr, exp_corr(x, bias_m[0]));
    check({tag, "_gy"}, gy_corr, exp_corr(y, bias_m[1]));
    check({tag, "_gz"}, gz_corr, exp_corr(z, bias_m[2]));
  endtask

  task automatic start_pulse();
    cal_start = 1'b0;
    repeat (3) tick();
    cal_start = 1'b1;
    repeat (4) tick();
  endtask

  // Calibrate on cal_v, then update the model bias to floor(mean) per axis.
  task automatic do_cal(input string tag);
    int n;
    int sum;
    int q;
    start_pulse();
    for (int i = 0; i < N; i++) send(cal_v[0][i], cal_v[1][i], cal_v[2][i], tag);
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_busy_drop"}, busy, 0);
    for (int a = 0; a < 3; a++) begin
      sum = 0;
      for (int i = 0; i < N; i++) sum += cal_v[a][i];
      q = sum / N;
      if ((sum % N != 0) && (sum < 0)) q--;
      bias_m[a] = q;
    end
    check({tag, "_cal_done"}, cal_done, 1);
  endtask

  task automatic fill_cal(input int vx, input int vy, input int vz);
    for (int i = 0; i < N; i++) begin
      cal_v[0][i] = vx;
      cal_v[1][i] = vy;
      cal_v[2][i] = vz;
    end
  endtask

  initial begin
    bias_m = '{0, 0, 0};

    // Reset state
    #23;
    check("rst_gx", gx_corr, 0);
    check("rst_valid", corr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", cal_done, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Passthrough before any calibration
    send(-1234, 777, 0, "pass");
    check("pass_done", cal_done, 0);
    tick();
    check("pass_valid_drop", corr_valid, 0);
    for (int i = 0; i < 4; i++) send(rnd_full(), rnd_full(), rnd_full(), "pass_rnd");

    // Constant 100 on all axes
    fill_cal(100, 100, 100);
    busy_cycles = 0;
    do_cal("const");
    check("const_busy_len", busy_cycles >= 17, 1);
    send(100, 100, 100, "const_zero");
    send(0, -100, 32767, "const_rnd");

    // Alternating 3 / -4 gives a floored bias of -1
    for (int i = 0; i < N; i++) begin
      cal_v[0][i] = (i % 2 == 0) ? 3 : -4;
      cal_v[1][i] = (i % 2 == 0) ? -4 : 3;
      cal_v[2][i] = (i % 2 == 0) ? 5 : -5;
    end
    do_cal("alt");
    check("alt_bias_model", bias_m[0], -1);
    send(0, 0, 0, "alt_probe");

    // Saturation at both extremes
    fill_cal(-32768, -32768, 32767);
    do_cal("satlo");
    send(32767, -32768, -32768, "satlo_probe");
    fill_cal(32767, 32767, 32767);
    do_cal("sathi");
    send(-32768, 32767, 0, "sathi_probe");

    // Randomized calibrations with random corrected samples
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 3; a++)
        for (int i = 0; i < N; i++) cal_v[a][i] = int'($urandom_range(0, 4000)) - 2000;
      do_cal("rnd_cal");
      for (int i = 0; i < 4; i++) send(rnd_full(), rnd_full(), rnd_full(), "rnd_corr");
    end

    // Restart after 10 samples: only the post-restart 16 count
    start_pulse();
    for (int i = 0; i < 10; i++) send(20000, -20000, 15000, "pre_restart");
    for (int a = 0; a < 3; a++)
      for (int i = 0; i < N; i++) cal_v[a][i] = int'($urandom_range(0, 600)) - 300;
    do_cal("restart");
    send(0, 0, 0, "restart_probe");

    // Held level triggers only once
    fill_cal(-50, 60, -70);
    do_cal("hold");
    busy_cycles = 0;
    repeat (1000) tick();
    check("hold_no_retrigger", busy_cycles, 0);
    send(-50, 60, -70, "hold_probe");

    // Asynchronous reset in the middle of accumulation
    start_pulse();
    for (int i = 0; i < 5; i++) send(1111, 2222, 3333, "mid_accum");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_gx", gx_corr, 0);
    check("async_rst_gy", gy_corr, 0);
    check("async_rst_gz", gz_corr, 0);
    check("async_rst_valid", corr_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", cal_done, 0);
    cal_start = 1'b0;
    bias_m = '{0, 0, 0};
    @(negedge clk_100mhz);
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", busy, 0);
    send(555, -555, 0, "post_rst");
    check("post_rst_done", cal_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
